// File: rtl/nametable_write_arb_if.sv
// Requester channels (scroll loader s0, CPU s1) plus the name/attribute table write ports
// of nametable_write_arb. The master side is the requester/RAM environment.
interface nametable_write_arb_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              wr_window;

    logic              s0_valid;
    logic              s0_ready;
    logic              s0_sel;
    logic [3:0]        s0_be;
    logic [ADDR_W-1:0] s0_addr;
    logic [31:0]       s0_data;
    logic              s0_last;

    logic              s1_valid;
    logic              s1_ready;
    logic              s1_sel;
    logic [3:0]        s1_be;
    logic [ADDR_W-1:0] s1_addr;
    logic [31:0]       s1_data;
    logic              s1_last;

    logic [3:0]        name_we;
    logic [ADDR_W-1:0] name_addr;
    logic [31:0]       name_data;
    logic [3:0]        attr_we;
    logic [ADDR_W-1:0] attr_addr;
    logic [31:0]       attr_data;

    logic [1:0]        owner;
    logic [15:0]       beat_cnt;

    modport master (
        output wr_window,
        output s0_valid, s0_sel, s0_be, s0_addr, s0_data, s0_last,
        output s1_valid, s1_sel, s1_be, s1_addr, s1_data, s1_last,
        input  s0_ready, s1_ready,
        input  name_we, name_addr, name_data, attr_we, attr_addr, attr_data,
        input  owner, beat_cnt
    );

    modport slave (
        input  wr_window,
        input  s0_valid, s0_sel, s0_be, s0_addr, s0_data, s0_last,
        input  s1_valid, s1_sel, s1_be, s1_addr, s1_data, s1_last,
        output s0_ready, s1_ready,
        output name_we, name_addr, name_data, attr_we, attr_addr, attr_data,
        output owner, beat_cnt
    );
endinterface

// File: rtl/nametable_write_arb.sv
// Round-robin arbiter between the scroll loader (s0) and the CPU (s1) for name/attribute
// table writes; data moves only inside the write window, write ports are registered.
module nametable_write_arb #(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned MAX_BURST = 16
) (
    input logic                  clk_100MHz,
    input logic                  rstn,
    nametable_write_arb_if.slave bus
);
    // Encoding doubles as the owner output.
    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StGrant0 = 2'b01,
        StGrant1 = 2'b10
    } state_e;

    localparam logic [7:0] BurstLast = 8'(MAX_BURST - 1);

    state_e            state_q;
    logic              prefer_s1_q;
    logic [7:0]        burst_q;
    logic [1:0]        quiet_q;

    logic              grant0;
    logic              grant1;
    logic              acc;
    logic              req_valid;
    logic              req_sel;
    logic              req_last;
    logic [3:0]        req_be;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;

    assign grant0       = (state_q == StGrant0);
    assign grant1       = (state_q == StGrant1);
    assign bus.s0_ready = grant0 && bus.wr_window;
    assign bus.s1_ready = grant1 && bus.wr_window;
    assign bus.owner    = state_q;

    always_comb begin
        req_valid = bus.s0_valid;
        req_sel   = bus.s0_sel;
        req_last  = bus.s0_last;
        req_be    = bus.s0_be;
        req_addr  = bus.s0_addr;
        req_data  = bus.s0_data;
        if (grant1) begin
            req_valid = bus.s1_valid;
            req_sel   = bus.s1_sel;
            req_last  = bus.s1_last;
            req_be    = bus.s1_be;
            req_addr  = bus.s1_addr;
            req_data  = bus.s1_data;
        end
    end

    assign acc = (grant0 || grant1) && req_valid && bus.wr_window;

    always_ff @(posedge clk_100MHz) begin
        if (!rstn) begin
            state_q       <= StIdle;
            prefer_s1_q   <= 1'b0;
            burst_q       <= '0;
            quiet_q       <= '0;
            bus.name_we   <= '0;
            bus.name_addr <= '0;
            bus.name_data <= '0;
            bus.attr_we   <= '0;
            bus.attr_addr <= '0;
            bus.attr_data <= '0;
            bus.beat_cnt  <= '0;
        end else begin
            bus.name_we <= '0;
            bus.attr_we <= '0;
            if (acc) begin
                bus.beat_cnt <= bus.beat_cnt + 16'd1;
                if (req_sel) begin
                    bus.attr_we   <= req_be;
                    bus.attr_addr <= req_addr;
                    bus.attr_data <= req_data;
                end else begin
                    bus.name_we   <= req_be;
                    bus.name_addr <= req_addr;
                    bus.name_data <= req_data;
                end
            end

            unique case (state_q)
                StIdle: begin
                    burst_q <= '0;
                    quiet_q <= '0;
                    if (bus.s0_valid && !(bus.s1_valid && prefer_s1_q)) begin
                        state_q     <= StGrant0;
                        prefer_s1_q <= 1'b1;
                    end else if (bus.s1_valid) begin
                        state_q     <= StGrant1;
                        prefer_s1_q <= 1'b0;
                    end
                end
                StGrant0, StGrant1: begin
                    if (acc) begin
                        quiet_q <= '0;
                        if (req_last || burst_q == BurstLast) begin
                            state_q <= StIdle;
                            burst_q <= '0;
                        end else begin
                            burst_q <= burst_q + 8'd1;
                        end
                    end else if (bus.wr_window && !req_valid) begin
                        // Requester went quiet with the window open: abandon after 4 cycles.
                        if (quiet_q == 2'd3) begin
                            state_q <= StIdle;
                            quiet_q <= '0;
                        end else begin
                            quiet_q <= quiet_q + 2'd1;
                        end
                    end else begin
                        quiet_q <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
